// File: rtl/cond_branch_seq_pkg.sv
// rtl/cond_branch_seq_pkg.sv - shared condition codes, sequencer states and evaluator encoding
package cond_pkg;

    typedef enum logic [2:0] {
        COND_NEVER  = 3'd0,
        COND_EQ     = 3'd1,
        COND_LT     = 3'd2,
        COND_LE     = 3'd3,
        COND_ALWAYS = 3'd4,
        COND_NE     = 3'd5,
        COND_GE     = 3'd6,
        COND_GT     = 3'd7
    } cond_t;

    typedef enum logic {
        IDLE = 1'b0,
        EVAL = 1'b1
    } seq_state_t;

    localparam int DEFAULT_PC_STEP = 4;

    // Evaluator Condition input is a full byte; only the low three bits carry the code.
    function automatic logic [7:0] cond_to_code(input logic [2:0] c);
        return {5'b00000, c};
    endfunction

endpackage

// File: rtl/cond_branch_seq_if.sv
// rtl/cond_branch_seq_if.sv - decode-to-sequencer instruction handshake
interface cond_branch_seq_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [2:0]            instr_cond;
    logic [7:0]            instr_value;
    logic [ADDR_WIDTH-1:0] instr_target;

    modport master (
        output instr_valid, instr_cond, instr_value, instr_target,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_cond, instr_value, instr_target,
        output instr_ready
    );
endinterface

// File: rtl/cond_branch_seq_sat_counter8.sv
// rtl/cond_branch_seq_sat_counter8.sv - 8-bit saturating up-counter with async reset
module sat_counter8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    output logic [7:0] count_o
);
    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/cond_branch_seq.sv
// rtl/cond_branch_seq.sv - conditional-branch PC sequencer driving an external condition evaluator
module cond_branch_seq
    import cond_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int RESET_PC   = 0,
    parameter int PC_STEP    = DEFAULT_PC_STEP
) (
    input  logic                  clk,
    input  logic                  rst,
    cond_branch_seq_if.slave      instr,
    output logic [7:0]            cond_code,
    output logic [7:0]            cond_value,
    input  logic                  cond_result,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_valid,
    output logic                  taken,
    output logic [7:0]            branch_count
);
    localparam logic [ADDR_WIDTH-1:0] PC_INC   = ADDR_WIDTH'(PC_STEP);
    localparam logic [ADDR_WIDTH-1:0] PC_RESET = ADDR_WIDTH'(RESET_PC);

    seq_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic [2:0]            cond_q, cond_d;
    logic [7:0]            value_q, value_d;
    logic                  pc_valid_q, pc_valid_d;
    logic                  taken_q, taken_d;
    logic                  ready;
    logic                  count_inc;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        cond_d     = cond_q;
        value_d    = value_q;
        pc_valid_d = 1'b0;
        taken_d    = 1'b0;
        ready      = 1'b0;
        count_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (instr.instr_valid) begin
                    state_d  = EVAL;
                    cond_d   = instr.instr_cond;
                    value_d  = instr.instr_value;
                    target_d = instr.instr_target;
                end
            end
            EVAL: begin
                state_d    = IDLE;
                pc_d       = cond_result ? target_q : (pc_q + PC_INC);
                pc_valid_d = 1'b1;
                taken_d    = cond_result;
                count_inc  = cond_result;
                // Back to "never" so the evaluator reports 0 while idle.
                cond_d     = 3'd0;
                value_d    = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= PC_RESET;
            target_q   <= '0;
            cond_q     <= 3'd0;
            value_q    <= 8'd0;
            pc_valid_q <= 1'b0;
            taken_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            cond_q     <= cond_d;
            value_q    <= value_d;
            pc_valid_q <= pc_valid_d;
            taken_q    <= taken_d;
        end
    end

    sat_counter8 u_branch_count (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (count_inc),
        .count_o (branch_count)
    );

    assign instr.instr_ready = ready;
    assign cond_code         = cond_to_code(cond_q);
    assign cond_value        = value_q;
    assign pc                = pc_q;
    assign pc_valid          = pc_valid_q;
    assign taken             = taken_q;
endmodule

// File: tb/tb_cond_branch_seq.sv
// tb/tb_cond_branch_seq.sv - directed self-checking bench for cond_branch_seq
module tb_cond_branch_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cond_code;
    logic [7:0] cond_value;
    logic       cond_result;
    logic [7:0] pc;
    logic       pc_valid;
    logic       taken;
    logic [7:0] branch_count;

    int checks   = 0;
    int failures = 0;

    cond_branch_seq_if #(.ADDR_WIDTH(8)) bus ();

    cond_branch_seq #(.ADDR_WIDTH(8), .RESET_PC(0), .PC_STEP(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (bus),
        .cond_code    (cond_code),
        .cond_value   (cond_value),
        .cond_result  (cond_result),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .taken        (taken),
        .branch_count (branch_count)
    );

    always #5 clk = ~clk;

    // Reference combinational evaluator on the far side of cond_code/cond_value.
    always_comb begin
        case (cond_code[2:0])
            3'd0:    cond_result = 1'b0;
            3'd1:    cond_result = (cond_value == 8'd0);
            3'd2:    cond_result = cond_value[7];
            3'd3:    cond_result = cond_value[7] || (cond_value == 8'd0);
            3'd4:    cond_result = 1'b1;
            3'd5:    cond_result = (cond_value != 8'd0);
            3'd6:    cond_result = !cond_value[7];
            default: cond_result = !cond_value[7] && (cond_value != 8'd0);
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 while IDLE; returns at posedge+1 of the pc_valid cycle.
    task automatic issue(input logic [2:0] c, input logic [7:0] v, input logic [7:0] t,
                         input logic [7:0] exp_pc, input logic exp_taken, input logic [7:0] exp_bc,
                         input string tag);
        bus.instr_valid  = 1'b1;
        bus.instr_cond   = c;
        bus.instr_value  = v;
        bus.instr_target = t;
        tick();
        bus.instr_valid = 1'b0;
        chk({tag, " eval_code"}, {24'd0, cond_code}, {29'd0, c});
        chk({tag, " eval_ready"}, {31'd0, bus.instr_ready}, 32'd0);
        tick();
        chk({tag, " pc"}, {24'd0, pc}, {24'd0, exp_pc});
        chk({tag, " taken"}, {31'd0, taken}, {31'd0, exp_taken});
        chk({tag, " pc_valid"}, {31'd0, pc_valid}, 32'd1);
        chk({tag, " branch_count"}, {24'd0, branch_count}, {24'd0, exp_bc});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts;
        logic acc;
        logic [7:0] exp_bc;
        logic [3:0] exp_rdy;
        logic [3:0] exp_pcv;

        bus.instr_valid  = 1'b0;
        bus.instr_cond   = 3'd0;
        bus.instr_value  = 8'd0;
        bus.instr_target = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("reset pc", {24'd0, pc}, 32'h00);
        chk("reset pc_valid", {31'd0, pc_valid}, 32'd0);
        chk("reset branch_count", {24'd0, branch_count}, 32'd0);
        chk("reset cond_code", {24'd0, cond_code}, 32'd0);
        chk("reset instr_ready", {31'd0, bus.instr_ready}, 32'd1);

        // Reset landing in the middle of EVAL drops the instruction.
        bus.instr_valid  = 1'b1;
        bus.instr_cond   = 3'd4;
        bus.instr_target = 8'h40;
        tick();
        bus.instr_valid = 1'b0;
        chk("midrst in_eval", {31'd0, bus.instr_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst pc", {24'd0, pc}, 32'h00);
        chk("midrst ready", {31'd0, bus.instr_ready}, 32'd1);
        chk("midrst cond_code", {24'd0, cond_code}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("midrst no_pulse", {31'd0, pc_valid}, 32'd0);
        chk("midrst pc_after", {24'd0, pc}, 32'h00);

        issue(3'd4, 8'h00, 8'h20, 8'h20, 1'b1, 8'd1, "always");
        issue(3'd0, 8'h00, 8'h99, 8'h24, 1'b0, 8'd1, "never");
        issue(3'd2, 8'h80, 8'h50, 8'h50, 1'b1, 8'd2, "lt_neg");
        issue(3'd2, 8'h7F, 8'h77, 8'h54, 1'b0, 8'd2, "lt_pos");
        issue(3'd1, 8'h00, 8'h60, 8'h60, 1'b1, 8'd3, "eq_zero");
        issue(3'd7, 8'h00, 8'h11, 8'h64, 1'b0, 8'd3, "gt_zero");
        issue(3'd6, 8'h00, 8'h70, 8'h70, 1'b1, 8'd4, "ge_zero");
        issue(3'd3, 8'h00, 8'h80, 8'h80, 1'b1, 8'd5, "le_zero");
        issue(3'd5, 8'h00, 8'h22, 8'h84, 1'b0, 8'd5, "ne_zero");
        issue(3'd4, 8'h00, 8'hFC, 8'hFC, 1'b1, 8'd6, "to_fc");
        issue(3'd0, 8'h00, 8'h33, 8'h00, 1'b0, 8'd6, "wrap");
        tick();
        chk("pulse_drop pc_valid", {31'd0, pc_valid}, 32'd0);
        chk("pulse_drop taken", {31'd0, taken}, 32'd0);
        chk("idle cond_code", {24'd0, cond_code}, 32'd0);

        // Valid held for four cycles; payload advances only after an accept.
        accepts          = 0;
        exp_rdy          = 4'b0101;
        exp_pcv          = 4'b1010;
        bus.instr_valid  = 1'b1;
        bus.instr_cond   = 3'd4;
        bus.instr_value  = 8'h00;
        bus.instr_target = 8'h10;
        for (int i = 0; i < 4; i++) begin
            chk("bp ready", {31'd0, bus.instr_ready}, {31'd0, exp_rdy[i]});
            acc = bus.instr_ready;
            tick();
            if (acc) begin
                accepts++;
                bus.instr_cond   = 3'd0;
                bus.instr_target = 8'h33;
            end
            chk("bp pc_valid", {31'd0, pc_valid}, {31'd0, exp_pcv[i]});
            if (i == 1) chk("bp pc_first", {24'd0, pc}, 32'h10);
        end
        bus.instr_valid = 1'b0;
        chk("bp accepts", accepts, 32'd2);
        chk("bp pc_final", {24'd0, pc}, 32'h14);
        chk("bp branch_count", {24'd0, branch_count}, 32'd7);

        exp_bc = 8'd7;
        for (int i = 0; i < 260; i++) begin
            if (exp_bc != 8'hFF) exp_bc = exp_bc + 8'd1;
            issue(3'd4, 8'h00, 8'(i * 7 + 3), 8'(i * 7 + 3), 1'b1, exp_bc, "sat");
        end
        chk("sat final", {24'd0, branch_count}, 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
